// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract engine.
// One full_adder cell is reused across WIDTH bit positions, LSB first, so a
// result costs WIDTH cycles of latency but only one adder cell.
//
// state | meaning
// IDLE  | waiting for Start_i
// RUN   | one bit per edge through the shared full_adder
// DONE  | one-cycle result strobe; a new Start_i is accepted here too
//
// Ports:
//   Clk_i    clock, rising edge
//   Rst_n_i  asynchronous active-low reset
//   Start_i  request pulse; A_i, B_i, Sub_i sampled on acceptance
//   Sub_i    0 = A+B, 1 = A-B
//   A_i/B_i  operands
//   Busy_o   high while in RUN
//   Done_o   one-cycle pulse, result valid
//   Sum_o    result, held until the next Done_o
//   C_o      carry out of the MSB (subtraction: 1 = no borrow)
//   V_o      signed overflow

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk_i,
    input  logic             Rst_n_i,
    input  logic             Start_i,
    input  logic             Sub_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Sum_o,
    output logic             C_o,
    output logic             V_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (op_a[cnt]),
        .b  (op_b[cnt]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Busy_o <= 1'b0;
            Done_o <= 1'b0;
            Sum_o  <= '0;
            C_o    <= 1'b0;
            V_o    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done_o <= 1'b0;
                    if (Start_i) begin
                        // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
                        op_a   <= A_i;
                        op_b   <= B_i ^ {WIDTH{Sub_i}};
                        carry  <= Sub_i;
                        cnt    <= '0;
                        res_sh <= '0;
                        state  <= RUN;
                        Busy_o <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        Busy_o <= 1'b0;
                    end
                end
                RUN: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    if (cnt == LAST_BIT) begin
                        // carry currently holds the carry into the MSB.
                        Sum_o  <= {fa_s, res_sh[WIDTH-1:1]};
                        C_o    <= fa_co;
                        V_o    <= carry ^ fa_co;
                        cnt    <= '0;
                        state  <= DONE;
                        Busy_o <= 1'b0;
                        Done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy_o <= 1'b0;
                    Done_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, c8, v8;
    logic [7:0] sum8;
    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, c4, v4;
    logic [3:0] sum4;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start8), .Sub_i(sub8),
        .A_i(a8), .B_i(b8), .Busy_o(busy8), .Done_o(done8),
        .Sum_o(sum8), .C_o(c8), .V_o(v8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start4), .Sub_i(sub4),
        .A_i(a4), .B_i(b4), .Busy_o(busy4), .Done_o(done4),
        .Sum_o(sum4), .C_o(c4), .V_o(v4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integer and signed-range rules.
    function automatic void ref_op(input int w, input bit sb, input longint a, input longint b,
                                   output longint sum, output bit c, output bit v);
        longint m, sa, sbv, r, sr;
        m   = longint'(1) << w;
        sa  = (a >= m / 2) ? a - m : a;
        sbv = (b >= m / 2) ? b - m : b;
        if (sb) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sbv;
        end else begin
            r  = a + b;
            c  = (r >= m);
            sr = sa + sbv;
        end
        sum = ((r % m) + m) % m;
        v   = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    // Timing model: an accepted request keeps the engine busy for w edges,
    // then the result shows for one cycle; requests while busy are dropped.
    int     m_left[2];
    bit     m_done[2];
    longint m_sum[2], p_sum[2];
    bit     m_c[2], m_v[2], p_c[2], p_v[2];

    task automatic model_step(input int i, input int w, input bit st, input bit sb,
                              input longint a, input longint b);
        if (m_left[i] != 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_done[i] = 1'b1;
                m_sum[i]  = p_sum[i];
                m_c[i]    = p_c[i];
                m_v[i]    = p_v[i];
            end else begin
                m_done[i] = 1'b0;
            end
        end else begin
            m_done[i] = 1'b0;
            if (st) begin
                ref_op(w, sb, a, b, p_sum[i], p_c[i], p_v[i]);
                m_left[i] = w;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] = 0;
                m_done[i] = 1'b0;
                m_sum[i]  = 0;
                m_c[i]    = 1'b0;
                m_v[i]    = 1'b0;
            end
        end else begin
            model_step(0, 8, start8, sub8, longint'(a8), longint'(b8));
            model_step(1, 4, start4, sub4, longint'(a4), longint'(b4));
        end
    end

    always @(negedge clk) begin
        check("busy8", busy8, m_left[0] != 0);
        check("done8", done8, m_done[0]);
        check("sum8",  sum8,  m_sum[0]);
        check("c8",    c8,    m_c[0]);
        check("v8",    v8,    m_v[0]);
        check("busy4", busy4, m_left[1] != 0);
        check("done4", done4, m_done[1]);
        check("sum4",  sum4,  m_sum[1]);
        check("c4",    c4,    m_c[1]);
        check("v4",    v4,    m_v[1]);
    end

    // Called on a negedge; returns on the following negedge with inputs scrambled.
    task automatic start8_op(input bit sb, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        sub8   = sb;
        a8     = a;
        b8     = b;
        @(negedge clk);
        start8 = 1'b0;
        sub8   = 1'($urandom);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
    endtask

    task automatic wait_done8(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!done8 && lat < 20) begin
            if (busy8) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_done8(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done8) cnt++;
        end
    endtask

    initial begin
        int     lat, nb, nd;
        longint ms;
        bit     mc, mv;

        ref_op(8, 1'b0, 'h5A, 'h3C, ms, mc, mv);
        check("model_add", {ms[7:0], 7'd0, mc, 7'd0, mv}, {8'h96, 8'h00, 8'h01});
        ref_op(8, 1'b1, 'h80, 'h01, ms, mc, mv);
        check("model_sub", {ms[7:0], 7'd0, mc, 7'd0, mv}, {8'h7F, 8'h01, 8'h01});
        ref_op(4, 1'b1, 'h0, 'h1, ms, mc, mv);
        check("model_sub4", {ms[3:0], 3'd0, mc, 3'd0, mv}, {4'hF, 4'h0, 4'h0});

        repeat (3) @(negedge clk);
        check("rst_outs8", {busy8, done8, sum8, c8, v8}, '0);
        check("rst_outs4", {busy4, done4, sum4, c4, v4}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        start8_op(1'b0, 8'h5A, 8'h3C);
        wait_done8(lat, nb);
        check("lat_5a3c", lat, 8);
        check("busy_len", nb, 8);
        check("res_5a3c", {sum8, c8, v8}, {8'h96, 1'b0, 1'b1});
        @(negedge clk);

        start8_op(1'b0, 8'hFF, 8'h01);
        wait_done8(lat, nb);
        check("res_ff01", {sum8, c8, v8}, {8'h00, 1'b1, 1'b0});
        @(negedge clk);

        start8_op(1'b1, 8'h10, 8'h20);
        wait_done8(lat, nb);
        check("res_1020", {sum8, c8, v8}, {8'hF0, 1'b0, 1'b0});
        start8_op(1'b1, 8'h80, 8'h01);
        wait_done8(lat, nb);
        check("lat_b2b", lat, 8);
        check("res_8001", {sum8, c8, v8}, {8'h7F, 1'b1, 1'b1});
        @(negedge clk);

        start8_op(1'b0, 8'h12, 8'h34);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        sub8   = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat, nb);
        check("res_ignore", {sum8, c8, v8}, {8'h46, 1'b0, 1'b0});
        count_done8(15, nd);
        check("one_done", nd, 0);

        start8_op(1'b0, 8'hA5, 8'h5A);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {busy8, done8, sum8, c8, v8}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done8(15, nd);
        check("abort_nodone", nd, 0);
        start8_op(1'b0, 8'h7F, 8'h01);
        wait_done8(lat, nb);
        check("lat_after_rst", lat, 8);
        check("res_7f01", {sum8, c8, v8}, {8'h80, 1'b0, 1'b1});
        @(negedge clk);

        repeat (400) begin
            start8 = ($urandom_range(0, 3) == 0);
            sub8   = 1'($urandom);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    start4 = 1'b1;
                    sub4   = 1'(s);
                    a4     = 4'(a);
                    b4     = 4'(b);
                    @(negedge clk);
                    start4 = 1'b0;
                    a4     = 4'($urandom);
                    b4     = 4'($urandom);
                    sub4   = 1'($urandom);
                    repeat (4) @(negedge clk);
                end
            end
        end
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
